// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit saturating-counter PHT, decode-stage prediction,
// execute-stage training and mispredict redirect, plus saturating performance counters.
module branch_predictor #(
    parameter int IDX_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_d,
    input  logic [31:0] immext_d,
    input  logic        is_branch_d,
    input  logic        is_jal_d,
    output logic        predict_taken_d,
    output logic [31:0] pred_target_d,
    input  logic        branch_e,
    input  logic        pred_taken_e,
    input  logic        taken_e,
    input  logic [31:0] pc_e,
    input  logic [31:0] target_e,
    input  logic [31:0] pc_plus4_e,
    output logic        redirect_e,
    output logic [31:0] redirect_pc_e,
    input  logic        clear_stats,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0]       pht_q [ENTRIES];
    logic [1:0]       pht_d [ENTRIES];
    logic [31:0]      branch_cnt_q, branch_cnt_d;
    logic [31:0]      mispred_cnt_q, mispred_cnt_d;
    logic [IDX_W-1:0] idx_d, idx_e;
    logic             unused_pc_bits;

    assign idx_d = pc_d[IDX_W+1:2];
    assign idx_e = pc_e[IDX_W+1:2];
    assign unused_pc_bits = ^{pc_e[31:IDX_W+2], pc_e[1:0]};

    // Prediction reads the registered PHT only, so a same-cycle update is seen next cycle.
    assign predict_taken_d = is_jal_d | (is_branch_d & pht_q[idx_d][1]);
    assign pred_target_d   = pc_d + immext_d;

    assign redirect_e    = branch_e & (taken_e != pred_taken_e);
    assign redirect_pc_e = taken_e ? target_e : pc_plus4_e;

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

    always_comb begin
        // NOTE: defaults first so every path assigns every signal; otherwise a latch is inferred.
        pht_d         = pht_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        if (branch_e) begin
            if (taken_e) begin
                if (pht_q[idx_e] != 2'b11) pht_d[idx_e] = pht_q[idx_e] + 2'd1;
            end else begin
                if (pht_q[idx_e] != 2'b00) pht_d[idx_e] = pht_q[idx_e] - 2'd1;
            end
        end

        if (clear_stats) begin
            branch_cnt_d  = '0;
            mispred_cnt_d = '0;
        end else begin
            if (branch_e && branch_cnt_q != 32'hFFFF_FFFF)
                branch_cnt_d = branch_cnt_q + 32'd1;
            if (redirect_e && mispred_cnt_q != 32'hFFFF_FFFF)
                mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    // NOTE: the PHT is built from flops, not RAM, so it can and must be reset to weakly not-taken.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) pht_q[i] <= 2'b01;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            pht_q         <= pht_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed corner cases plus random traffic
// compared against a counter-per-entry reference model.
module tb_branch_predictor;

    localparam int IDX_W   = 6;
    localparam int ENTRIES = 1 << IDX_W;
    localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_d, immext_d;
    logic        is_branch_d, is_jal_d;
    logic        predict_taken_d;
    logic [31:0] pred_target_d;
    logic        branch_e, pred_taken_e, taken_e;
    logic [31:0] pc_e, target_e, pc_plus4_e;
    logic        redirect_e;
    logic [31:0] redirect_pc_e;
    logic        clear_stats;
    logic [31:0] branch_cnt, mispred_cnt;

    int     checks = 0;
    int     errors = 0;
    int     m_pht [ENTRIES];
    longint m_bcnt, m_mcnt;

    branch_predictor #(.IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset),
        .pc_d(pc_d), .immext_d(immext_d),
        .is_branch_d(is_branch_d), .is_jal_d(is_jal_d),
        .predict_taken_d(predict_taken_d), .pred_target_d(pred_target_d),
        .branch_e(branch_e), .pred_taken_e(pred_taken_e), .taken_e(taken_e),
        .pc_e(pc_e), .target_e(target_e), .pc_plus4_e(pc_plus4_e),
        .redirect_e(redirect_e), .redirect_pc_e(redirect_pc_e),
        .clear_stats(clear_stats),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int entry_of(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_pht[i] = 1;
        m_bcnt = 0;
        m_mcnt = 0;
    endtask

    task automatic check_comb(input string tag);
        logic exp_pred, exp_redir;
        exp_pred  = is_jal_d || (is_branch_d && m_pht[entry_of(pc_d)] >= 2);
        exp_redir = branch_e && (taken_e != pred_taken_e);
        check({tag, ".pred"},   {31'd0, predict_taken_d}, {31'd0, exp_pred});
        check({tag, ".target"}, pred_target_d, pc_d + immext_d);
        check({tag, ".redir"},  {31'd0, redirect_e}, {31'd0, exp_redir});
        check({tag, ".rpc"},    redirect_pc_e, taken_e ? target_e : pc_plus4_e);
    endtask

    // One clock: check combinational outputs, advance the model, clock, check counters.
    task automatic tick(input string tag);
        int  e;
        bit  mis;
        #1;
        check_comb(tag);
        mis = branch_e && (taken_e != pred_taken_e);
        if (branch_e) begin
            e = entry_of(pc_e);
            m_pht[e] = taken_e ? ((m_pht[e] + 1 > 3) ? 3 : m_pht[e] + 1)
                               : ((m_pht[e] - 1 < 0) ? 0 : m_pht[e] - 1);
        end
        if (clear_stats) begin
            m_bcnt = 0;
            m_mcnt = 0;
        end else begin
            if (branch_e && m_bcnt < CNT_MAX) m_bcnt++;
            if (mis && m_mcnt < CNT_MAX) m_mcnt++;
        end
        @(posedge clk);
        #1;
        check({tag, ".bcnt"}, branch_cnt, m_bcnt[31:0]);
        check({tag, ".mcnt"}, mispred_cnt, m_mcnt[31:0]);
    endtask

    task automatic set_e(input logic br, input logic pt, input logic tk, input logic [31:0] pc);
        branch_e     = br;
        pred_taken_e = pt;
        taken_e      = tk;
        pc_e         = pc;
        target_e     = pc + 32'h40;
        pc_plus4_e   = pc + 32'd4;
    endtask

    initial begin
        reset = 1'b1;
        pc_d = 32'h0; immext_d = 32'h0; is_branch_d = 1'b0; is_jal_d = 1'b0;
        set_e(1'b0, 1'b0, 1'b0, 32'h0);
        clear_stats = 1'b0;
        model_reset();

        // Reset state: every entry weakly not-taken, counters clear.
        #2;
        check("reset.bcnt", branch_cnt, 32'd0);
        check("reset.mcnt", mispred_cnt, 32'd0);
        is_branch_d = 1'b1;
        for (int i = 0; i < ENTRIES; i++) begin
            pc_d = 32'(i * 4);
            #1;
            check("reset.pht", {31'd0, predict_taken_d}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Prediction at 0x100 with negative offset wraps correctly.
        pc_d = 32'h100; immext_d = 32'hFFFF_FFF0;
        tick("d028");
        check("d028.tgt", pred_target_d, 32'h0000_00F0);

        // Train 0x100 to strongly taken, saturate, then step back to weakly taken.
        set_e(1'b1, 1'b0, 1'b1, 32'h100);
        tick("d029.t1");
        tick("d029.t2");
        check("d029.strong", {31'd0, predict_taken_d}, 32'd1);
        set_e(1'b1, 1'b1, 1'b1, 32'h100);
        tick("d029.t3");
        set_e(1'b1, 1'b1, 1'b0, 32'h100);
        tick("d029.nt");
        set_e(1'b0, 1'b0, 1'b0, 32'h0);
        tick("d029.weak");
        check("d029.weak_taken", {31'd0, predict_taken_d}, 32'd1);

        // Mispredict redirects in both directions.
        branch_e = 1'b1; pred_taken_e = 1'b0; taken_e = 1'b1;
        pc_e = 32'h300; target_e = 32'h200; pc_plus4_e = 32'h304;
        #1;
        check("d030.redir", {31'd0, redirect_e}, 32'd1);
        check("d030.rpc", redirect_pc_e, 32'h200);
        tick("d030.a");
        pred_taken_e = 1'b1; taken_e = 1'b0; pc_e = 32'h100; pc_plus4_e = 32'h104;
        #1;
        check("d030.rpc_nt", redirect_pc_e, 32'h104);
        tick("d030.b");

        // Aliasing: 0x100 and 0x200 share an entry; the update is not bypassed.
        set_e(1'b0, 1'b0, 1'b0, 32'h0);
        set_e(1'b1, 1'b0, 1'b0, 32'h200);
        tick("d031.down");
        pc_d = 32'h100; is_branch_d = 1'b1;
        set_e(1'b1, 1'b0, 1'b1, 32'h200);
        #1;
        check("d031.old", {31'd0, predict_taken_d}, 32'd0);
        tick("d031.same");
        set_e(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check("d031.new", {31'd0, predict_taken_d}, 32'd1);
        tick("d031.next");

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            pc_d        = $urandom & 32'h0000_03FC;
            immext_d    = $urandom;
            is_branch_d = $urandom_range(0, 1) != 0;
            is_jal_d    = $urandom_range(0, 7) == 0;
            set_e($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                  $urandom_range(0, 1) != 0, $urandom & 32'h0000_03FC);
            target_e    = $urandom;
            clear_stats = $urandom_range(0, 31) == 0;
            tick("rand");
        end
        clear_stats = 1'b0;

        // Clear overrides a simultaneous branch and mispredict.
        set_e(1'b1, 1'b0, 1'b1, 32'h40);
        clear_stats = 1'b1;
        tick("d032.clr");
        check("d032.bzero", branch_cnt, 32'd0);
        check("d032.mzero", mispred_cnt, 32'd0);
        clear_stats = 1'b0;

        // Branch counter saturates at all-ones.
        force dut.branch_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.branch_cnt_q;
        m_bcnt = CNT_MAX;
        set_e(1'b1, 1'b1, 1'b1, 32'h40);
        tick("d032.sat1");
        tick("d032.sat2");
        check("d032.sat", branch_cnt, 32'hFFFF_FFFF);

        // Asynchronous reset between edges with trained entries; pending update discarded.
        set_e(1'b0, 1'b0, 1'b0, 32'h0);
        pc_d = 32'h40; is_branch_d = 1'b1; is_jal_d = 1'b0;
        #1;
        check("d033.trained", {31'd0, predict_taken_d}, 32'd1);
        set_e(1'b1, 1'b1, 1'b1, 32'h80);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("d033.bcnt", branch_cnt, 32'd0);
        check("d033.mcnt", mispred_cnt, 32'd0);
        check("d033.pred", {31'd0, predict_taken_d}, 32'd0);
        is_jal_d = 1'b1;
        #1;
        check("d033.jal", {31'd0, predict_taken_d}, 32'd1);
        is_jal_d = 1'b0; pc_d = 32'h80;
        @(posedge clk);
        #1;
        check("d033.held", {31'd0, predict_taken_d}, 32'd0);
        check("d033.held_bcnt", branch_cnt, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        set_e(1'b0, 1'b0, 1'b0, 32'h0);
        tick("d033.post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
